pp_final_adder: RTL and testbench

- Final carry-propagate stage of the 32x32 radix-4 Booth multiplier. Sits directly downstream of the partial-product compressor tree.
- Takes the redundant carry/sum pair, C[62:0] and S[63:0], and produces the 64-bit product P = S + (C << 1) mod 2^64.
- Pipelined over two stages, split at bit SPLIT, with valid/ready flow control and a passthrough tag so the multiplier can be issued back-to-back.

---
 rtl/pp_final_adder.sv | 135 +++++++++++++
 tb/tb_pp_final_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pp_final_adder.sv
// pp_final_adder: final carry-propagate adder of the 32x32 radix-4 Booth multiplier.
// Converts the redundant carry/sum pair into P = S + (C << 1) mod 2^64.
// Two pipeline stages split at bit SPLIT, with valid/ready flow control and a
// passthrough tag. Occupancy is at most two ops, and results leave in strict FIFO order.

module pp_final_adder #(
   parameter int SPLIT = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [62:0]      in_c,
   input  logic [63:0]      in_s,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_product,
   output logic [TAG_W-1:0] out_tag
);

   localparam int HI_W = 64 - SPLIT;

   // Stage 1: low-segment sum with its carry, untouched high operands, and the tag.
   logic             s1_valid_q, s1_valid_d;
   logic [SPLIT-1:0] s1_lo_q,    s1_lo_d;
   logic             s1_cy_q,    s1_cy_d;
   logic [HI_W-1:0]  s1_a_hi_q,  s1_a_hi_d;
   logic [HI_W-1:0]  s1_b_hi_q,  s1_b_hi_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

   // Stage 2: the finished product and the tag.
   logic             s2_valid_q,   s2_valid_d;
   logic [63:0]      s2_product_q, s2_product_d;
   logic [TAG_W-1:0] s2_tag_q,     s2_tag_d;

   logic [63:0]      op_a;
   logic [63:0]      op_b;
   logic [SPLIT:0]   lo_sum;
   logic [HI_W-1:0]  hi_sum;
   logic             s2_free;
   logic             s1_adv;
   logic             accept;

   // Handshake: ready ripples back from out_ready only; in_valid never feeds in_ready.
   always_comb begin
      s2_free  = !s2_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_free;
      in_ready = !s1_valid_q || s2_free;
      accept   = in_valid && in_ready;
   end

   // Stage 1 arithmetic: align the carry vector and add the low segment.
   // The extra MSB of lo_sum is the carry into the high segment.
   always_comb begin
      op_a   = {in_c, 1'b0};
      op_b   = in_s;
      lo_sum = {1'b0, op_a[SPLIT-1:0]} + {1'b0, op_b[SPLIT-1:0]};
   end

   // Stage 2 arithmetic: finish the high segment. The carry out of bit 63 is dropped.
   always_comb begin
      hi_sum = s1_a_hi_q + s1_b_hi_q + HI_W'(s1_cy_q);
   end

   // Next-state logic. Datapath registers change only on their stage enable,
   // so garbage on in_c/in_s while in_valid is low never reaches the output.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      s1_valid_d   = s1_valid_q;
      s1_lo_d      = s1_lo_q;
      s1_cy_d      = s1_cy_q;
      s1_a_hi_d    = s1_a_hi_q;
      s1_b_hi_d    = s1_b_hi_q;
      s1_tag_d     = s1_tag_q;
      s2_valid_d   = s2_valid_q;
      s2_product_d = s2_product_q;
      s2_tag_d     = s2_tag_q;

      if (accept) begin
         s1_lo_d   = lo_sum[SPLIT-1:0];
         s1_cy_d   = lo_sum[SPLIT];
         s1_a_hi_d = op_a[63:SPLIT];
         s1_b_hi_d = op_b[63:SPLIT];
         s1_tag_d  = in_tag;
      end

      if (accept) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
         s2_valid_d   = 1'b1;
         s2_product_d = {hi_sum, s1_lo_q};
         s2_tag_d     = s1_tag_q;
      end else if (out_ready) begin
         s2_valid_d   = 1'b0;
      end
   end

   // State registers. Reset clears the valids and the datapath, which drops any in-flight ops.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath flops are reset too, so out_product/out_tag read 0 out of reset;
      // all sequential state uses non-blocking assignments.
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_lo_q      <= '0;
         s1_cy_q      <= 1'b0;
         s1_a_hi_q    <= '0;
         s1_b_hi_q    <= '0;
         s1_tag_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_product_q <= '0;
         s2_tag_q     <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_lo_q      <= s1_lo_d;
         s1_cy_q      <= s1_cy_d;
         s1_a_hi_q    <= s1_a_hi_d;
         s1_b_hi_q    <= s1_b_hi_d;
         s1_tag_q     <= s1_tag_d;
         s2_valid_q   <= s2_valid_d;
         s2_product_q <= s2_product_d;
         s2_tag_q     <= s2_tag_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_product = s2_product_q;
   assign out_tag     = s2_tag_q;

endmodule

// File: tb/tb_pp_final_adder.sv
// tb_pp_final_adder: table-driven vectors plus hand-written sequences, checked
// through a scoreboard queue. Inputs change just after the falling edge and outputs
// are sampled 1 time unit later, well away from the rising edge.

module tb_pp_final_adder;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [62:0]      in_c;
   logic [63:0]      in_s;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_product;
   logic [TAG_W-1:0] out_tag;

   pp_final_adder #(.SPLIT(32), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_c        (in_c),
      .in_s        (in_s),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [62:0]      c;
      logic [63:0]      s;
      logic [TAG_W-1:0] tag;
      logic [63:0]      exp;
   } vec_t;

   typedef struct {
      logic [63:0]      p;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // One clock cycle: drive, sample, update scoreboard. The transfer itself happens
   // on the rising edge that follows the sample point.
   task automatic cyc(input logic v, input logic [62:0] c, input logic [63:0] s,
                      input logic [TAG_W-1:0] tag, input logic [63:0] exp, input logic ordy,
                      output logic acc, output logic ov, output logic ir);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_c      = c;
      in_s      = s;
      in_tag    = tag;
      out_ready = ordy;
      #1;
      acc = in_valid && in_ready;
      ov  = out_valid;
      ir  = in_ready;
      if (acc) sb.push_back('{p: exp, tag: tag});
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_output: got %h tag %0d, expected no output", out_product, out_tag);
         end else begin
            e = sb.pop_front();
            check("product", out_product, e.p);
            check("tag", 64'(out_tag), 64'(e.tag));
         end
      end
   endtask

   task automatic idle(input logic ordy, output logic ov, output logic ir);
      logic acc;
      cyc(1'b0, 'x, 'x, '0, '0, ordy, acc, ov, ir);
   endtask

   function automatic logic [63:0] golden(input logic [62:0] c, input logic [63:0] s);
      return s + {c, 1'b0};
   endfunction

   initial begin
      vec_t        vt[7];
      logic        acc, ov, ir;
      logic [63:0] r;
      logic [62:0] rc;
      logic [63:0] rs;
      int          k, outs, stalls;

      vt[0] = '{c: 63'h0,                     s: 64'h5,                     tag: 4'd1, exp: 64'h5};
      vt[1] = '{c: 63'h1,                     s: 64'h0000_0000_FFFF_FFFF,   tag: 4'd2, exp: 64'h0000_0001_0000_0001};
      vt[2] = '{c: 63'h1,                     s: 64'hFFFF_FFFF_FFFF_FFFF,   tag: 4'd3, exp: 64'h1};
      vt[3] = '{c: 63'h7FFF_FFFF_FFFF_FFFF,   s: 64'h2,                     tag: 4'd4, exp: 64'h0};
      vt[4] = '{c: 63'h3,                     s: 64'h10,                    tag: 4'd5, exp: 64'h16};
      vt[5] = '{c: 63'h4000_0000_0000_0000,   s: 64'h8000_0000_0000_0000,   tag: 4'd6, exp: 64'h0};
      vt[6] = '{c: 63'h7FFF_FFFF,             s: 64'h2,                     tag: 4'd7, exp: 64'h1_0000_0000};

      // Reset state.
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_c      = '0;
      in_s      = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_product", out_product, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table vectors, one at a time, with latency: accepted at edge N,
      // not valid after N, valid (and consumed) after N+1.
      foreach (vt[i]) begin
         cyc(1'b1, vt[i].c, vt[i].s, vt[i].tag, vt[i].exp, 1'b1, acc, ov, ir);
         check("vec_accept", 64'(acc), 64'd1);
         idle(1'b1, ov, ir);
         check("vec_lat_early", 64'(ov), 64'd0);
         idle(1'b1, ov, ir);
         check("vec_lat_valid", 64'(ov), 64'd1);
      end

      // Backpressure: 4 back-to-back ops, out_ready low for 3 cycles from the
      // first cycle out_valid is high.
      cyc(1'b1, 63'h0, 64'd10, 4'd0, 64'd10, 1'b1, acc, ov, ir);
      cyc(1'b1, 63'h0, 64'd20, 4'd1, 64'd20, 1'b1, acc, ov, ir);
      for (int h = 0; h < 3; h++) begin
         cyc(1'b1, 63'h0, 64'd30, 4'd2, 64'd30, 1'b0, acc, ov, ir);
         check("bp_out_valid", 64'(ov), 64'd1);
         check("bp_in_ready_low", 64'(ir), 64'd0);
         check("bp_hold_product", out_product, 64'd10);
         check("bp_hold_tag", 64'(out_tag), 64'd0);
      end
      k = 2;
      for (int t = 0; t < 20 && (k < 4 || sb.size() != 0); t++) begin
         if (k < 4) begin
            cyc(1'b1, 63'h0, 64'(10 * (k + 1)), TAG_W'(k), 64'(10 * (k + 1)), 1'b1, acc, ov, ir);
            if (acc) k++;
         end else begin
            idle(1'b1, ov, ir);
         end
      end
      check("bp_all_issued", 64'(k), 64'd4);
      check("bp_drained", 64'(sb.size()), 64'd0);

      // Full-rate streaming: one result per cycle once the pipe has filled.
      outs   = 0;
      stalls = 0;
      for (int i = 0; i < 1000; i++) begin
         r  = {$urandom(), $urandom()};
         rc = r[62:0];
         rs = {$urandom(), $urandom()};
         cyc(1'b1, rc, rs, TAG_W'(i), golden(rc, rs), 1'b1, acc, ov, ir);
         if (!ir) stalls++;
         if (ov) outs++;
      end
      check("stream_no_stall", 64'(stalls), 64'd0);
      check("stream_one_per_cycle", 64'(outs), 64'd998);
      for (int t = 0; t < 10 && sb.size() != 0; t++) idle(1'b1, ov, ir);
      check("stream_drained", 64'(sb.size()), 64'd0);

      // Random in_valid/out_ready toggling.
      for (int i = 0; i < 600; i++) begin
         r  = {$urandom(), $urandom()};
         rc = r[62:0];
         rs = {$urandom(), $urandom()};
         cyc(1'($urandom_range(0, 1)), rc, rs, TAG_W'($urandom()), golden(rc, rs),
             1'(($urandom() % 4) != 0), acc, ov, ir);
      end
      for (int t = 0; t < 20 && sb.size() != 0; t++) idle(1'b1, ov, ir);
      check("random_drained", 64'(sb.size()), 64'd0);

      // Reset mid-operation with both stages full.
      cyc(1'b1, 63'h0, 64'd100, 4'd8, 64'd100, 1'b0, acc, ov, ir);
      cyc(1'b1, 63'h0, 64'd200, 4'd9, 64'd200, 1'b0, acc, ov, ir);
      idle(1'b0, ov, ir);
      check("full_out_valid", 64'(ov), 64'd1);
      check("full_in_ready", 64'(ir), 64'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      check("async_rst_product", out_product, 64'd0);
      sb.delete();
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 63'h0, 64'd7, 4'd5, 64'd7, 1'b1, acc, ov, ir);
      check("post_rst_accept", 64'(acc), 64'd1);
      for (int t = 0; t < 5; t++) idle(1'b1, ov, ir);
      check("post_rst_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
